// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants for the hex display controller: the segment width and the
// active-low seven-segment codes (bit6 = a ... bit0 = g).
package hex_display_ctrl_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0001100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Minimum-1 bit width for a counter that must hold values 0..n-1.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/hex_display_ctrl_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import hex_display_ctrl_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Map each nibble value to its glyph; unreachable default shows blank.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Hex display controller: drives NUM_DIGITS digits both as static segment
// fields (hex_o) and as a time-multiplexed scan (seg_o/an_o). New values are
// staged in a shadow register and committed only on a frame boundary so a
// scan frame never shows a mix of old and new digits.
module hex_display_ctrl
    import hex_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [4*NUM_DIGITS-1:0]     data_i,
    input  logic                        load_i,
    input  logic                        blank_lz_i,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_o,
    output logic [SEG_W-1:0]            seg_o,
    output logic [NUM_DIGITS-1:0]       an_o,
    output logic                        pending_o,
    output logic                        frame_o
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int HW = SEG_W * NUM_DIGITS;
    localparam int PW = cnt_width(REFRESH_DIV);
    localparam int SW = cnt_width(NUM_DIGITS);

    localparam logic [PW-1:0] CNT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_DIGITS - 1);

    logic [PW-1:0]         count_r;
    logic [SW-1:0]         scan_r;
    logic                  tick_s;
    logic                  frame_s;

    logic [DW-1:0]         active_r;
    logic [DW-1:0]         shadow_r;
    logic                  pending_r;

    logic [NUM_DIGITS-1:0] zero_from_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic [HW-1:0]         dec_s;
    logic [HW-1:0]         hex_next_s;
    logic [3:0]            scan_nib_s;
    logic                  scan_blank_s;
    logic [SEG_W-1:0]      scan_dec_s;
    logic [SEG_W-1:0]      seg_next_s;
    logic [NUM_DIGITS-1:0] an_next_s;

    logic [HW-1:0]         hex_r;
    logic [SEG_W-1:0]      seg_r;
    logic [NUM_DIGITS-1:0] an_r;

    // The frame boundary must coincide with the commit cycle, so it is decoded
    // straight from the counter state (and suppressed while reset is held).
    assign tick_s  = (count_r == CNT_LAST);
    assign frame_s = tick_s && (scan_r == SCAN_LAST) && !reset;

    // Prescaler: counts 0..REFRESH_DIV-1 and wraps on tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {PW{1'b0}};
        end else if (tick_s) begin
            count_r <= {PW{1'b0}};
        end else begin
            count_r <= count_r + PW'(1);
        end
    end

    // Scan index: advances once per tick, wrapping after the last digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_r <= {SW{1'b0}};
        end else if (tick_s) begin
            if (scan_r == SCAN_LAST) begin
                scan_r <= {SW{1'b0}};
            end else begin
                scan_r <= scan_r + SW'(1);
            end
        end else begin
            scan_r <= scan_r;
        end
    end

    // Shadow/active staging: loads wait in the shadow until a frame boundary;
    // a load on the boundary itself bypasses the shadow and drops any older one.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_r  <= {DW{1'b0}};
            shadow_r  <= {DW{1'b0}};
            pending_r <= 1'b0;
        end else if (frame_s) begin
            if (load_i) begin
                active_r <= data_i;
            end else if (pending_r) begin
                active_r <= shadow_r;
            end else begin
                active_r <= active_r;
            end
            shadow_r  <= shadow_r;
            pending_r <= 1'b0;
        end else if (load_i) begin
            active_r  <= active_r;
            shadow_r  <= data_i;
            pending_r <= 1'b1;
        end else begin
            active_r  <= active_r;
            shadow_r  <= shadow_r;
            pending_r <= pending_r;
        end
    end

    // Leading-zero detection: zero_from_s[k] is set when nibbles k..top are
    // all zero; digit 0 is never blanked so a zero value still shows "0".
    always_comb begin
        logic zero_run_s;
        zero_run_s  = 1'b1;
        zero_from_s = {NUM_DIGITS{1'b0}};
        blank_s     = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s     = zero_run_s && (active_r[4*k +: 4] == 4'h0);
            zero_from_s[k] = zero_run_s;
            blank_s[k]     = blank_lz_i && (k != 0) && zero_run_s;
        end
    end

    // One decoder per static digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        hex_to_seg7 u_dec (
            .nibble (active_r[4*g +: 4]),
            .seg    (dec_s[SEG_W*g +: SEG_W])
        );
    end

    // A separate decoder for the scanned digit.
    hex_to_seg7 u_scan_dec (
        .nibble (scan_nib_s),
        .seg    (scan_dec_s)
    );

    // Select the scanned nibble, its blanking and the one-cold anode pattern.
    always_comb begin
        scan_nib_s   = 4'h0;
        scan_blank_s = 1'b0;
        an_next_s    = {NUM_DIGITS{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_r == SW'(k)) begin
                scan_nib_s   = active_r[4*k +: 4];
                scan_blank_s = blank_s[k];
                an_next_s[k] = 1'b0;
            end else begin
                an_next_s[k] = 1'b1;
            end
        end
    end

    // Apply blanking to the decoded static and scanned glyphs.
    always_comb begin
        hex_next_s = {HW{1'b1}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (blank_s[k]) begin
                hex_next_s[SEG_W*k +: SEG_W] = SEG_BLANK;
            end else begin
                hex_next_s[SEG_W*k +: SEG_W] = dec_s[SEG_W*k +: SEG_W];
            end
        end
        if (scan_blank_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = scan_dec_s;
        end
    end

    // Output registers: everything dark while in reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_r <= {HW{1'b1}};
            seg_r <= SEG_BLANK;
            an_r  <= {NUM_DIGITS{1'b1}};
        end else begin
            hex_r <= hex_next_s;
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign hex_o     = hex_r;
    assign seg_o     = seg_r;
    assign an_o      = an_r;
    assign pending_o = pending_r;
    assign frame_o   = frame_s;

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, number of hex digits (legal range 1..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 50000, clock cycles per scan step (>=1).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port data_i, input, 4*NUM_DIGITS, the value to display; nibble k maps to digit k, and digit 0 is the least significant.
REQ-006 The block SHALL have port load_i, input, 1, a single-cycle request to capture data_i.
REQ-007 The block SHALL have port blank_lz_i, input, 1, which enables leading-zero blanking.
REQ-008 The block SHALL have port hex_o, output, 7*NUM_DIGITS, the static segments; digit k occupies bits [7k+6:7k].
REQ-009 The block SHALL have port seg_o, output, 7, the multiplexed segments of the currently scanned digit.
REQ-010 The block SHALL have port an_o, output, NUM_DIGITS, the active-low one-hot digit enable.
REQ-011 The block SHALL have port pending_o, output, 1, which is high while a captured value awaits commit.
REQ-012 The block SHALL have port frame_o, output, 1, a one-cycle pulse at each frame boundary.

Function
REQ-013 Segment codes SHALL be active-low, with bit6=a and bit0=g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, blank=1111111.
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick is asserted in the cycle where count==REFRESH_DIV-1.
REQ-015 With REFRESH_DIV=1, tick SHALL be asserted every cycle.
REQ-016 On tick, the scan index SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-017 A frame boundary SHALL be a tick with scan index==NUM_DIGITS-1; frame_o SHALL be high for exactly that cycle.
REQ-018 load_i=1 SHALL capture data_i into a shadow register and set pending_o in the next cycle.
REQ-019 Repeated loads before commit SHALL overwrite the shadow register; the last load wins.
REQ-020 At a frame boundary with pending set, shadow SHALL copy into the active register and pending SHALL clear.
REQ-021 If load_i coincides with a frame boundary, data_i SHALL commit directly to the active register; pending_o SHALL be 0 afterwards, and any older shadow value is discarded.
REQ-022 hex_o, seg_o and an_o SHALL be registered, changing exactly 1 cycle after the active register, scan index or blank_lz_i change.
REQ-023 Leading-zero blanking: digit k>0 SHALL show blank when blank_lz_i=1 and nibbles k..NUM_DIGITS-1 of the active register are all zero; digit 0 SHALL never be blanked.
REQ-024 seg_o SHALL equal the hex_o field of the scanned digit, with identical blanking; an_o SHALL drive bit[scan index] low and all other bits high.

Reset
REQ-025 On reset=1, the active and shadow registers, prescaler and scan index SHALL clear to 0, pending_o=0 and frame_o=0.
REQ-026 On reset=1, hex_o SHALL be all ones (all blank), seg_o=1111111 and an_o SHALL be all ones.
REQ-027 Reset asserted mid-frame SHALL discard any pending value; the prescaler SHALL restart from 0 on the first cycle after release.
REQ-028 In the first cycle after reset release, outputs SHALL display the active value 0 per REQ-023.

Structure
REQ-029 A shared package SHALL hold the SEG_0..SEG_F and SEG_BLANK constants and the segment width constant (7).
REQ-030 The block SHALL instantiate one combinational sub-module, hex_to_seg7 (4-bit in, 7-bit out), per digit plus once for seg_o.
REQ-031 Prescaler width SHALL be clog2(REFRESH_DIV), minimum 1; scan index width SHALL be clog2(NUM_DIGITS), minimum 1.

Verification (NUM_DIGITS=6, REFRESH_DIV=4)
REQ-032 Reset held 3 cycles, then released -> during reset hex_o=all ones and an_o=111111; 1 cycle after release hex_o=six copies of 0000001 and an_o=111110.
REQ-033 load 24'h00BEEF mid-frame -> pending_o=1 and hex_o unchanged until frame_o; 1 cycle after frame_o hex_o digits 5..0 = 0,0,b,E,E,F and pending_o=0.
REQ-034 blank_lz_i=1 with active 24'h0012F0 -> digits 5,4 blank and digits 3..0 = 1,2,F,0; with active 0 -> digits 5..1 blank and digit 0 shows 0000001.
REQ-035 Free-running scan -> an_o steps 111110, 111101, ..., 011111 every 4 cycles; frame_o pulses every 24 cycles; seg_o matches the enabled digit's hex_o field.
REQ-036 load 24'h111111, then load 24'h222222 in the same frame, then load 24'h333333 exactly on the frame_o cycle -> display shows 333333 and pending_o=0 afterwards.
REQ-037 Reset pulse while pending_o=1 -> pending_o=0, the display returns to 0 and the first frame_o arrives 24 cycles after release.
